// File: rtl/axi_read_vector_hs_if.sv
// AXI-stream channel carrying tdata/tvalid/tready/tlast between a source and a sink.
interface axi_stream_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi_read_vector_hs.sv
// AXI-stream vector reader: assembles a runtime-length vector of ELEM_W-bit elements behind a
// valid/ready result handshake. Define AXI_READ_VECTOR_HS_CLEAR_EN to zero the buffer on each start.
package axi_read_vector_hs_pkg;
    typedef enum logic {DIR__RIGHT, DIR__LEFT} dir_e;
endpackage

module axi_read_vector_hs
    import axi_read_vector_hs_pkg::*;
#(
    parameter int   MAX_VEC_LENGTH   = 64,
    parameter int   ELEM_W           = 1,
    parameter int   AXI_DATA_WIDTH   = 8,
    parameter dir_e READ_DIR         = DIR__RIGHT,
    parameter int   MAX_VEC_LENGTH_W = ($clog2(MAX_VEC_LENGTH + 1) < 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [MAX_VEC_LENGTH_W-1:0]          vec_length,
    axi_stream_if.slave                          data_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [MAX_VEC_LENGTH*ELEM_W-1:0]     vec,
    output logic                                 last,
    output logic                                 err
);
    localparam int VW         = MAX_VEC_LENGTH * ELEM_W;
    localparam int MAX_CHUNKS = (VW + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH;
    localparam int PW         = MAX_CHUNKS * AXI_DATA_WIDTH;
    localparam int CNT_W      = ($clog2(MAX_CHUNKS + 1) < 1) ? 1 : $clog2(MAX_CHUNKS + 1);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [CNT_W-1:0]   beats_reg, beats_next;
    logic               last_reg, last_next;
    logic               err_reg, err_next;
    logic               chunk_we;
    logic               read_ready;
    logic               accept_start;
    logic               len_err;
    logic [31:0]        len_32;
    logic [CNT_W-1:0]   beats_calc;
    logic [PW-1:0]      p_flat;

    // Over-long requests are clamped and flagged; beat count derives from the clamped length.
    assign len_err      = 32'(vec_length) > 32'(MAX_VEC_LENGTH);
    assign len_32       = len_err ? 32'(MAX_VEC_LENGTH) : 32'(vec_length);
    assign beats_calc   = CNT_W'((len_32 * 32'(ELEM_W) + 32'(AXI_DATA_WIDTH) - 32'd1) / 32'(AXI_DATA_WIDTH));
    assign accept_start = start && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            beats_reg    <= '0;
            last_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            beats_reg    <= beats_next;
            last_reg     <= last_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        beats_next    = beats_reg;
        last_next     = last_reg;
        err_next      = err_reg;
        chunk_we      = 1'b0;
        read_ready    = 1'b0;
        case (state_reg)
            IDLE: ;
            READ: begin
                read_ready = 1'b1;
                if (data_in.tvalid) begin
                    chunk_we      = 1'b1;
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    if (beat_cnt_reg == beats_reg - CNT_W'(1)) begin
                        last_next  = data_in.tlast;
                        state_next = DONE;
                    end else if (data_in.tlast) begin
                        last_next  = 1'b1;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A start accepted in DONE overrides the return to IDLE for zero-gap vectors.
        if (accept_start) begin
            beats_next    = beats_calc;
            beat_cnt_next = '0;
            last_next     = 1'b0;
            err_next      = len_err;
            state_next    = (beats_calc == '0) ? DONE : READ;
        end
    end

    // tready is held low while reset is asserted so nothing is consumed in that cycle.
    assign data_in.tready = read_ready && !rst;
    assign out_valid      = (state_reg == DONE);
    assign last           = last_reg;
    assign err            = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_CHUNKS; gi++) begin : g_chunk
            logic [AXI_DATA_WIDTH-1:0] chunk_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    chunk_reg <= '0;
`ifdef AXI_READ_VECTOR_HS_CLEAR_EN
                end else if (accept_start) begin
                    chunk_reg <= '0;
`endif
                end else if (chunk_we && (beat_cnt_reg == CNT_W'(gi))) begin
                    chunk_reg <= data_in.tdata;
                end
            end
            assign p_flat[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = chunk_reg;
        end

        if (READ_DIR == DIR__LEFT) begin : g_left
            assign vec = p_flat[PW-1 -: VW];
        end else begin : g_right
            assign vec = p_flat[VW-1:0];
        end
    endgenerate
endmodule

// File: doc/axi_read_vector_hs.md
Name: axi_read_vector_hs

Overview:
- Parametrised successor to the single-bit AXI-stream vector reader.
- Assembles a runtime-length vector of ELEM_W-bit elements from an AXI-stream slave into one wide register.
- Holds the result behind a valid/ready output handshake and flags stream/length mismatches.
- Sits between puzzle-input DMA streams and the per-row compute engines; supports back-to-back vectors without idle cycles.

Parameters:
- MAX_VEC_LENGTH, 64: maximum elements per vector.
- ELEM_W, 1: bits per element. Vector width VW = MAX_VEC_LENGTH*ELEM_W.
- AXI_DATA_WIDTH, 8: tdata width in bits.
- READ_DIR, DIR__RIGHT: dir_e; selects which end of the padded buffer is output.
- MAX_VEC_LENGTH_W, $clog2(MAX_VEC_LENGTH+1) (min 1): width of vec_length.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new vector; sampled only in IDLE, or in DONE on the cycle out_ready is high.
- vec_length  input  MAX_VEC_LENGTH_W  element count, sampled with an accepted start.
- data_in  axi_stream_if.slave  AXI_DATA_WIDTH  tdata/tvalid/tready/tlast input stream.
- out_valid  output  1  vec/last/err are valid.
- out_ready  input  1  consumer accepts the result.
- vec  output  VW  assembled vector.
- last  output  1  tlast was seen on the final consumed beat.
- err  output  1  length/stream mismatch for this vector.

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-read:
  - state=IDLE, tready=0, out_valid=0, last=0, err=0, vec=0.
  - Beat counter cleared; no beat is consumed in the reset cycle.
- Chunk geometry:
  - MAX_CHUNKS = ceil(VW/AXI_DATA_WIDTH); padded buffer P is MAX_CHUNKS*AXI_DATA_WIDTH bits.
  - Chunk k is written to P[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
- Beat count at start: L = min(vec_length, MAX_VEC_LENGTH); N = ceil(L*ELEM_W/AXI_DATA_WIDTH), computed in 32 bits.
- vec_length > MAX_VEC_LENGTH: clamp to MAX_VEC_LENGTH and set err for this vector.
- Output mapping:
  - READ_DIR=DIR__RIGHT: vec = P[VW-1:0].
  - READ_DIR=DIR__LEFT: vec = P[top VW bits].
- IDLE state:
  - tready=0.
  - start=1 with N>0: latch N, clear last/err, go to READ.
  - start=1 with N=0: go directly to DONE with last=0, err=0 (clamp error still applies); no beats consumed.
- READ state:
  - tready=1 combinationally.
  - Each tvalid beat writes chunk i and increments i.
  - If tlast arrives on beat i<N-1: set err=1, last=1, go to DONE. Remaining chunks are not written.
  - On beat i==N-1: last=tlast, go to DONE.
  - No beat is consumed beyond N.
- DONE state:
  - tready=0, out_valid=1; vec/last/err stable until out_ready=1.
  - out_ready=1 with start=0: go to IDLE.
  - out_ready=1 with start=1: accept the new start that cycle and go to READ (or stay in DONE if N=0). This gives zero idle cycles between vectors.
- Latency: out_valid rises the cycle after the final beat handshake.
- start outside IDLE or DONE&&out_ready is ignored.
- Chunk indices not written this vector retain prior contents (see Optional Feature).
- Beat counter width is $clog2(MAX_CHUNKS+1); it never wraps because it stops at N.

Optional Feature:
- Macro: AXI_READ_VECTOR_HS_CLEAR_EN.
- Defined: P is cleared to 0 on every accepted start, so vec bits beyond L*ELEM_W, or left unwritten after an early tlast, read as 0.
- Undefined: no clear. Stale bits from earlier vectors remain, and P needs no reset beyond the rst clear.

Test Plan (AXI_DATA_WIDTH=8, ELEM_W=1, MAX_VEC_LENGTH=20 unless noted):
- RIGHT, start with vec_length=20, beats 0xA5, 0x3C, 0x0F (tlast on 3rd) -> out_valid the cycle after beat 3; vec=0xF3CA5, last=1, err=0; tready low in DONE.
- LEFT, same stimulus -> vec=0x0F3CA, last=1, err=0.
- vec_length=20, tlast on the 2nd beat (0x11, 0x22) -> DONE after 2 beats, err=1, last=1; 3rd beat not consumed (tready=0).
- vec_length=25 -> clamped to 3 beats, err=1; vec_length=0 -> out_valid next cycle, no tready pulse, err=0.
- Hold out_ready=0 for 5 cycles -> vec stable, tready=0; then out_ready=1 with start=1 and vec_length=8 -> READ the next cycle, 1 beat 0x5A, vec[7:0]=0x5A (with CLEAR_EN, upper bits 0).
- Assert rst mid-READ after 1 beat -> next cycle IDLE, out_valid=0, vec=0, tready=0; a following full read completes normally.
